// File: rtl/seq_shift_engine_pkg.sv
//------------------------------------------------------------------------------
// Module   : seq_shift_pkg
// Brief    : Shared mode and state encodings for the sequential shift engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_shift_pkg;

   typedef logic [2:0] mode_t;

   localparam mode_t MODE_LSL0 = 3'b000;
   localparam mode_t MODE_LSL1 = 3'b001;
   localparam mode_t MODE_LSR0 = 3'b010;
   localparam mode_t MODE_LSR1 = 3'b011;
   localparam mode_t MODE_ASL  = 3'b100;
   localparam mode_t MODE_ASR  = 3'b101;
   localparam mode_t MODE_ROL  = 3'b110;
   localparam mode_t MODE_ROR  = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic logic is_rotate(input mode_t m);
      return (m == MODE_ROL) || (m == MODE_ROR);
   endfunction

   // Modes whose fill is always 0: once the value is zero it stays zero.
   function automatic logic is_zero_fill_mode(input mode_t m);
      return (m == MODE_LSL0) || (m == MODE_LSR0) || (m == MODE_ASL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shift_engine_if.sv
//------------------------------------------------------------------------------
// Module   : seq_shift_engine_if
// Brief    : Start/done handshake and operand/result bus of the shift engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_shift_engine_if #(
   parameter int N = 4
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [2:0]   mode;
   logic         ready;
   logic         busy;
   logic         done;
   logic [N-1:0] res;
   logic         CB_out;

   modport master (
      output start, A, B, mode,
      input  ready, busy, done, res, CB_out
   );

   modport slave (
      input  start, A, B, mode,
      output ready, busy, done, res, CB_out
   );
endinterface

`default_nettype wire

// File: rtl/seq_shift_engine_shift_step.sv
//------------------------------------------------------------------------------
// Module   : shift_step
// Brief    : Combinational single-position shift/rotate step for all 8 modes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_step
   import seq_shift_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] value,
   input  mode_t        mode,
   output logic [N-1:0] next_value,
   output logic         out_bit
);

   always_comb begin
      next_value = value;
      out_bit    = 1'b0;
      case (mode)
         MODE_LSL0, MODE_ASL: begin
            next_value = {value[N-2:0], 1'b0};
            out_bit    = value[N-1];
         end
         MODE_LSL1: begin
            next_value = {value[N-2:0], 1'b1};
            out_bit    = value[N-1];
         end
         MODE_LSR0: begin
            next_value = {1'b0, value[N-1:1]};
            out_bit    = value[0];
         end
         MODE_LSR1: begin
            next_value = {1'b1, value[N-1:1]};
            out_bit    = value[0];
         end
         MODE_ASR: begin
            next_value = {value[N-1], value[N-1:1]};
            out_bit    = value[0];
         end
         MODE_ROL: begin
            next_value = {value[N-2:0], value[N-1]};
            out_bit    = value[N-1];
         end
         MODE_ROR: begin
            next_value = {value[0], value[N-1:1]};
            out_bit    = value[0];
         end
         default: begin
            next_value = value;
            out_bit    = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/seq_shift_engine.sv
//------------------------------------------------------------------------------
// Module   : seq_shift_engine
// Brief    : Multi-cycle shifter, one bit position per clock, start/done
//            handshake. Optional macro SHIFT_EARLY_EXIT_EN ends zero-fill
//            shifts early once the working value is all-zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_shift_engine
   import seq_shift_pkg::*;
#(
   parameter int N  = 4,
   parameter int CW = $clog2(N) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   seq_shift_engine_if.slave   bus
);

   logic [1:0]    r_state;
   logic [1:0]    w_state_next;
   logic [N-1:0]  r_work;
   mode_t         r_mode;
   logic [CW-1:0] r_count;
   logic          r_cb;
   logic [CW-1:0] w_k;
   logic [N-1:0]  w_step_value;
   logic          w_step_bit;
   logic          w_early_exit;

   shift_step #(
      .N (N)
   ) u_shift_step (
      .value      (r_work),
      .mode       (r_mode),
      .next_value (w_step_value),
      .out_bit    (w_step_bit)
   );

   // Rotates wrap modulo N; every other mode saturates at N steps.
   always_comb begin
      if (is_rotate(bus.mode)) begin
         w_k = CW'(bus.B % N'(N));
      end else if (bus.B >= N'(N)) begin
         w_k = CW'(N);
      end else begin
         w_k = CW'(bus.B);
      end
   end

`ifdef SHIFT_EARLY_EXIT_EN
   assign w_early_exit = is_zero_fill_mode(r_mode) && (r_work == '0);
`else
   assign w_early_exit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_state_next = (w_k == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (w_early_exit || (r_count == CW'(1))) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.ready = 1'b0;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (r_state)
         ST_IDLE:  bus.ready = 1'b1;
         ST_SHIFT: bus.busy  = 1'b1;
         ST_DONE:  bus.done  = 1'b1;
         default:  bus.ready = 1'b0;
      endcase
   end

   // Working register doubles as the result; it only moves on start or shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work  <= '0;
         r_mode  <= MODE_LSL0;
         r_count <= '0;
         r_cb    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_work  <= bus.A;
                  r_mode  <= bus.mode;
                  r_count <= w_k;
                  r_cb    <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (!w_early_exit) begin
                  r_work  <= w_step_value;
                  r_cb    <= w_step_bit;
                  r_count <= r_count - CW'(1);
               end
            end
            default: begin
               r_work <= r_work;
            end
         endcase
      end
   end

   assign bus.res    = r_work;
   assign bus.CB_out = r_cb;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_engine.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_shift_engine
// Brief    : Directed, table-driven self-checking bench for seq_shift_engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_shift_engine;
   import seq_shift_pkg::*;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      mode_t      mode;
      logic [3:0] res;
      logic       cb;
      int         lat;
      logic       inject;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs[13];

   always #5 clk = ~clk;

   seq_shift_engine_if #(.N(4)) bus ();

   seq_shift_engine #(.N(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
      chk({tag, "_busy"},  32'(bus.busy),  32'd0);
      chk({tag, "_done"},  32'(bus.done),  32'd0);
      chk({tag, "_res"},   32'(bus.res),   32'd0);
      chk({tag, "_cb"},    32'(bus.CB_out), 32'd0);
   endtask

   task automatic run_op(input vec_t v, input int idx);
      int n;
      bus.A     = v.a;
      bus.B     = v.b;
      bus.mode  = v.mode;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk($sformatf("v%0d_not_ready", idx), 32'(bus.ready), 32'd0);
      n = 1;
      while (!bus.done && n < 20) begin
         // A second start while busy, with different operands, must be ignored.
         if (v.inject && n == 2) begin
            bus.start = 1'b1;
            bus.A     = 4'b1111;
            bus.B     = 4'd1;
            bus.mode  = MODE_LSL1;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         n++;
      end
      chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.lat));
      chk($sformatf("v%0d_res", idx), 32'(bus.res), 32'(v.res));
      chk($sformatf("v%0d_cb", idx), 32'(bus.CB_out), 32'(v.cb));
      chk($sformatf("v%0d_busy_at_done", idx), 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", idx), 32'(bus.done), 32'd0);
      chk($sformatf("v%0d_ready_after", idx), 32'(bus.ready), 32'd1);
      chk($sformatf("v%0d_res_held", idx), 32'(bus.res), 32'(v.res));
   endtask

   initial begin
      //           a        b      mode        res      cb    lat inject
      vecs[0]  = '{4'b1011, 4'd2,  MODE_LSL0, 4'b1100, 1'b0, 3, 1'b0};
      vecs[1]  = '{4'b1000, 4'd3,  MODE_ASR,  4'b1111, 1'b0, 4, 1'b0};
      vecs[2]  = '{4'b1001, 4'd5,  MODE_ROL,  4'b0011, 1'b1, 2, 1'b0};
      vecs[3]  = '{4'b0110, 4'd0,  MODE_LSR1, 4'b0110, 1'b0, 1, 1'b0};
`ifdef SHIFT_EARLY_EXIT_EN
      vecs[4]  = '{4'b0001, 4'd9,  MODE_LSR0, 4'b0000, 1'b1, 3, 1'b1};
`else
      vecs[4]  = '{4'b0001, 4'd9,  MODE_LSR0, 4'b0000, 1'b0, 5, 1'b1};
`endif
      vecs[5]  = '{4'b0101, 4'd2,  MODE_LSL1, 4'b0111, 1'b1, 3, 1'b0};
      vecs[6]  = '{4'b0100, 4'd15, MODE_LSR1, 4'b1111, 1'b0, 5, 1'b0};
      vecs[7]  = '{4'b0110, 4'd3,  MODE_ASL,  4'b0000, 1'b1, 4, 1'b0};
      vecs[8]  = '{4'b0110, 4'd7,  MODE_ASR,  4'b0000, 1'b0, 5, 1'b0};
      vecs[9]  = '{4'b1101, 4'd6,  MODE_ROR,  4'b0111, 1'b0, 3, 1'b0};
      vecs[10] = '{4'b1100, 4'd4,  MODE_ROL,  4'b1100, 1'b0, 1, 1'b0};
`ifdef SHIFT_EARLY_EXIT_EN
      vecs[11] = '{4'b0000, 4'd3,  MODE_LSL0, 4'b0000, 1'b0, 2, 1'b0};
`else
      vecs[11] = '{4'b0000, 4'd3,  MODE_LSL0, 4'b0000, 1'b0, 4, 1'b0};
`endif
      vecs[12] = '{4'b1011, 4'd4,  MODE_LSL0, 4'b0000, 1'b1, 5, 1'b0};

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.mode  = MODE_LSL0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i], i);
      end

      // Reset asserted mid-operation aborts with no done pulse.
      bus.A     = 4'b1111;
      bus.B     = 4'd3;
      bus.mode  = MODE_LSL0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("abort_busy_before", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk($sformatf("abort_no_done%0d", i), 32'(bus.done), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_reset_outputs("abort_release");
      run_op(vecs[0], 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
